pong_match_ctrl: RTL and testbench

Match sequencer for the Pong game datapath. It derives a once-per-frame tick from the raster counters and runs the serve / play / point / game-over state machine. It keeps both players' scores and drives the ball enable, ball recentre and serve direction controls consumed by the game/render block. It sits between the CRT driver's `xpos`/`ypos` outputs and the game datapath, in the `clk25` domain.

---
 rtl/pong_match_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_pong_match_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_match_ctrl.sv
// Match sequencer for Pong: frame tick from raster position, serve/play/point/over FSM, scores.
// Optional attract mode (ball live on the title screen) is enabled by defining PONG_ATTRACT_EN.
module pong_match_ctrl #(
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 30,
  parameter int WIN_SCORE    = 7
) (
  input  logic       clk25,
  input  logic       Reset,
  input  logic [9:0] xpos,
  input  logic [9:0] ypos,
  input  logic       start,
  input  logic       miss_left,
  input  logic       miss_right,
  output logic       frame_tick,
  output logic       ball_en,
  output logic       ball_reset,
  output logic       serve_dir,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic       game_over,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
  } state_t;

  localparam logic [9:0] LP_VACT  = 10'(V_ACTIVE);
  localparam logic [7:0] LP_SERVE = 8'(SERVE_FRAMES);
  localparam logic [7:0] LP_POINT = 8'(POINT_FRAMES);
  localparam logic [3:0] LP_WIN   = 4'(WIN_SCORE);

  if (H_ACTIVE < 1 || V_ACTIVE < 1 || V_ACTIVE > 1023 ||
      SERVE_FRAMES < 1 || SERVE_FRAMES > 255 ||
      POINT_FRAMES < 1 || POINT_FRAMES > 255 ||
      WIN_SCORE < 1 || WIN_SCORE > 15) begin : g_bad_param
    $error("pong_match_ctrl: parameter out of range");
  end

  state_t     r_state;
  logic [7:0] r_cnt;
  logic [3:0] r_score_l;
  logic [3:0] r_score_r;
  logic       r_serve_dir;
  logic       r_frame_tick;
  logic       r_start_q;
  logic       r_ball_en;
  logic       r_ball_reset;
  logic       r_game_over;

  logic       w_start_evt;
  logic [3:0] w_score_l_inc;
  logic [3:0] w_score_r_inc;

  assign w_start_evt   = start & ~r_start_q;
  assign w_score_l_inc = r_score_l + 4'd1;
  assign w_score_r_inc = r_score_r + 4'd1;

  // {ball_en, ball_reset, game_over} for the state being entered or held
  function automatic logic [2:0] f_outs(input state_t s);
    case (s)
`ifdef PONG_ATTRACT_EN
      IDLE:    f_outs = 3'b100;
`else
      IDLE:    f_outs = 3'b010;
`endif
      SERVE:   f_outs = 3'b010;
      PLAY:    f_outs = 3'b100;
      POINT:   f_outs = 3'b000;
      OVER:    f_outs = 3'b011;
      default: f_outs = 3'b010;
    endcase
  endfunction

  always_ff @(posedge clk25 or negedge Reset) begin
    if (!Reset) begin
      r_state      <= IDLE;
      r_cnt        <= 8'd0;
      r_score_l    <= 4'd0;
      r_score_r    <= 4'd0;
      r_serve_dir  <= 1'b1;
      r_frame_tick <= 1'b0;
      r_start_q    <= 1'b0;
      r_ball_en    <= 1'b0;
      r_ball_reset <= 1'b1;
      r_game_over  <= 1'b0;
    end else begin
      r_start_q    <= start;
      r_frame_tick <= (xpos == 10'd0) && (ypos == LP_VACT);
      {r_ball_en, r_ball_reset, r_game_over} <= f_outs(r_state);
      case (r_state)
        IDLE, OVER: begin
          if (w_start_evt) begin
            r_score_l <= 4'd0;
            r_score_r <= 4'd0;
            r_cnt     <= LP_SERVE;
            r_state   <= SERVE;
            {r_ball_en, r_ball_reset, r_game_over} <= f_outs(SERVE);
          end
`ifdef PONG_ATTRACT_EN
          // title-screen rally: a miss only recentres the ball and flips direction
          else if (r_state == IDLE && (miss_left || miss_right)) begin
            r_ball_reset <= 1'b1;
            r_serve_dir  <= ~r_serve_dir;
          end
`endif
        end
        SERVE: begin
          if (r_frame_tick) begin
            if (r_cnt <= 8'd1) begin
              r_cnt   <= 8'd0;
              r_state <= PLAY;
              {r_ball_en, r_ball_reset, r_game_over} <= f_outs(PLAY);
            end else begin
              r_cnt <= r_cnt - 8'd1;
            end
          end
        end
        PLAY: begin
          if (miss_left && miss_right) begin
            r_cnt   <= LP_POINT;
            r_state <= POINT;
            {r_ball_en, r_ball_reset, r_game_over} <= f_outs(POINT);
          end else if (miss_left) begin
            r_score_r   <= w_score_r_inc;
            r_serve_dir <= 1'b0;
            if (w_score_r_inc == LP_WIN) begin
              r_state <= OVER;
              {r_ball_en, r_ball_reset, r_game_over} <= f_outs(OVER);
            end else begin
              r_cnt   <= LP_POINT;
              r_state <= POINT;
              {r_ball_en, r_ball_reset, r_game_over} <= f_outs(POINT);
            end
          end else if (miss_right) begin
            r_score_l   <= w_score_l_inc;
            r_serve_dir <= 1'b1;
            if (w_score_l_inc == LP_WIN) begin
              r_state <= OVER;
              {r_ball_en, r_ball_reset, r_game_over} <= f_outs(OVER);
            end else begin
              r_cnt   <= LP_POINT;
              r_state <= POINT;
              {r_ball_en, r_ball_reset, r_game_over} <= f_outs(POINT);
            end
          end
        end
        POINT: begin
          if (r_frame_tick) begin
            if (r_cnt <= 8'd1) begin
              r_cnt   <= LP_SERVE;
              r_state <= SERVE;
              {r_ball_en, r_ball_reset, r_game_over} <= f_outs(SERVE);
            end else begin
              r_cnt <= r_cnt - 8'd1;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          {r_ball_en, r_ball_reset, r_game_over} <= f_outs(IDLE);
        end
      endcase
    end
  end

  assign frame_tick = r_frame_tick;
  assign ball_en    = r_ball_en;
  assign ball_reset = r_ball_reset;
  assign serve_dir  = r_serve_dir;
  assign score_l    = r_score_l;
  assign score_r    = r_score_r;
  assign game_over  = r_game_over;
  assign state      = r_state;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Randomized bench for pong_match_ctrl: stimulus pushes model predictions, a monitor pops and compares.
module tb_pong_match_ctrl;
  localparam int SF = 3;
  localparam int PF = 2;
  localparam int WIN = 2;
  localparam int VA = 480;
  localparam int NCYC = 20000;
  localparam int RST_AT = 7000;

  localparam int S_IDLE = 0, S_SERVE = 1, S_PLAY = 2, S_POINT = 3, S_OVER = 4;

`ifdef PONG_ATTRACT_EN
  localparam bit ATTRACT = 1'b1;
`else
  localparam bit ATTRACT = 1'b0;
`endif

  logic       clk25 = 1'b0;
  logic       Reset = 1'b0;
  logic [9:0] xpos = '0;
  logic [9:0] ypos = '0;
  logic       start = 1'b0;
  logic       miss_left = 1'b0;
  logic       miss_right = 1'b0;
  logic       frame_tick, ball_en, ball_reset, serve_dir, game_over;
  logic [3:0] score_l, score_r;
  logic [2:0] state;

  always #20 clk25 = ~clk25;

  pong_match_ctrl #(
    .H_ACTIVE(640), .V_ACTIVE(VA), .SERVE_FRAMES(SF), .POINT_FRAMES(PF), .WIN_SCORE(WIN)
  ) dut (
    .clk25(clk25), .Reset(Reset), .xpos(xpos), .ypos(ypos), .start(start),
    .miss_left(miss_left), .miss_right(miss_right), .frame_tick(frame_tick),
    .ball_en(ball_en), .ball_reset(ball_reset), .serve_dir(serve_dir),
    .score_l(score_l), .score_r(score_r), .game_over(game_over), .state(state)
  );

  typedef struct packed {
    logic       tick;
    logic       en;
    logic       rst;
    logic       dir;
    logic       over;
    logic [3:0] sl;
    logic [3:0] sr;
    logic [2:0] st;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int n_over = 0;
  int n_draw = 0;

  // reference match state, kept as plain counts and flags
  int m_state, m_frames_left, m_sl, m_sr;
  bit m_dir, m_tick, m_prev_start, m_pulse;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, got, want);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_state"}, 32'(state), 32'(S_IDLE));
    chk({tag, "_score_l"}, 32'(score_l), 32'd0);
    chk({tag, "_score_r"}, 32'(score_r), 32'd0);
    chk({tag, "_serve_dir"}, 32'(serve_dir), 32'd1);
    chk({tag, "_frame_tick"}, 32'(frame_tick), 32'd0);
    chk({tag, "_ball_en"}, 32'(ball_en), 32'd0);
    chk({tag, "_ball_reset"}, 32'(ball_reset), 32'd1);
    chk({tag, "_game_over"}, 32'(game_over), 32'd0);
  endtask

  function automatic void model_reset();
    m_state = S_IDLE; m_frames_left = 0; m_sl = 0; m_sr = 0;
    m_dir = 1'b1; m_tick = 1'b0; m_prev_start = 1'b0; m_pulse = 1'b0;
  endfunction

  function automatic void new_match();
    m_sl = 0; m_sr = 0; m_frames_left = SF; m_state = S_SERVE;
  endfunction

  function automatic void after_point(input int new_score);
    if (new_score == WIN) begin
      m_state = S_OVER;
      n_over++;
    end else begin
      m_state = S_POINT;
      m_frames_left = PF;
    end
  endfunction

  // one clock of the match rules, given the inputs sampled at that edge
  function automatic void model_step(input bit st, input bit ml, input bit mr, input int x, input int y);
    bit start_evt;
    bit tick_seen;
    start_evt = st && !m_prev_start;
    tick_seen = m_tick;
    m_prev_start = st;
    m_tick = (x == 0 && y == VA);
    m_pulse = 1'b0;
    if (m_state == S_IDLE) begin
      if (start_evt) new_match();
      else if (ATTRACT && (ml || mr)) begin
        m_pulse = 1'b1;
        m_dir = !m_dir;
      end
    end else if (m_state == S_OVER) begin
      if (start_evt) new_match();
    end else if (m_state == S_SERVE) begin
      if (tick_seen) begin
        m_frames_left--;
        if (m_frames_left == 0) m_state = S_PLAY;
      end
    end else if (m_state == S_POINT) begin
      if (tick_seen) begin
        m_frames_left--;
        if (m_frames_left == 0) begin
          m_frames_left = SF;
          m_state = S_SERVE;
        end
      end
    end else if (m_state == S_PLAY) begin
      if (ml && mr) begin
        n_draw++;
        m_state = S_POINT;
        m_frames_left = PF;
      end else if (ml) begin
        m_sr++;
        m_dir = 1'b0;
        after_point(m_sr);
      end else if (mr) begin
        m_sl++;
        m_dir = 1'b1;
        after_point(m_sl);
      end
    end
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.tick = m_tick;
    e.dir  = m_dir;
    e.sl   = 4'(m_sl);
    e.sr   = 4'(m_sr);
    e.st   = 3'(m_state);
    e.over = (m_state == S_OVER);
    if (m_state == S_PLAY) begin
      e.en = 1'b1; e.rst = 1'b0;
    end else if (m_state == S_POINT) begin
      e.en = 1'b0; e.rst = 1'b0;
    end else if (m_state == S_IDLE && ATTRACT) begin
      e.en = 1'b1; e.rst = m_pulse;
    end else begin
      e.en = 1'b0; e.rst = 1'b1;
    end
    return e;
  endfunction

  // monitor: one prediction per clock edge, compared shortly after the edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk25);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("frame_tick", 32'(frame_tick), 32'(e.tick));
        chk("ball_en", 32'(ball_en), 32'(e.en));
        chk("ball_reset", 32'(ball_reset), 32'(e.rst));
        chk("serve_dir", 32'(serve_dir), 32'(e.dir));
        chk("game_over", 32'(game_over), 32'(e.over));
        chk("score_l", 32'(score_l), 32'(e.sl));
        chk("score_r", 32'(score_r), 32'(e.sr));
        chk("state", 32'(state), 32'(e.st));
      end
    end
  end

  initial begin
    int r;
    bit ml, mr;
    model_reset();
    Reset = 1'b0;
    repeat (3) @(negedge clk25);
    chk_reset_outs("por");

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk25);
      r = $urandom_range(0, 7);
      if (r < 2) begin
        xpos = 10'd0; ypos = 10'(VA);
      end else if (r == 2) begin
        xpos = 10'd0; ypos = 10'(VA - 1);
      end else if (r == 3) begin
        xpos = 10'd1; ypos = 10'(VA);
      end else begin
        xpos = 10'($urandom_range(0, 799)); ypos = 10'($urandom_range(0, 524));
      end
      ml = 1'b0; mr = 1'b0;
      if (m_state == S_PLAY) begin
        r = $urandom_range(0, 15);
        if (r == 0) begin ml = 1'b1; mr = 1'b1; end
        else if (r == 1) ml = 1'b1;
        else if (r == 2) mr = 1'b1;
      end else begin
        r = $urandom_range(0, 9);
        if (r == 0) ml = 1'b1;
        else if (r == 1) mr = 1'b1;
        else if (r == 2) begin ml = 1'b1; mr = 1'b1; end
      end
      miss_left = ml;
      miss_right = mr;
      if ($urandom_range(0, 24) == 0) start = ~start;

      if (cyc >= RST_AT && cyc < RST_AT + 4) begin
        Reset = 1'b0;
        model_reset();
        exp_q.push_back(model_out());
        if (cyc == RST_AT) begin
          #1;
          chk_reset_outs("midrst");
        end
      end else begin
        Reset = 1'b1;
        model_step(start, ml, mr, int'(xpos), int'(ypos));
        exp_q.push_back(model_out());
      end
    end

    repeat (2) @(posedge clk25);
    #2;
    chk("drain", 32'(exp_q.size()), 32'd0);
    chk("cov_over", 32'(n_over > 0), 32'd1);
    chk("cov_draw", 32'(n_draw > 0), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
